// File: rtl/fpadd_accumulator.sv
// Frame accumulator around an external combinational FP32 adder: sums samples and reports sum/count/overflow.
// Latency: last-sample accept to out_valid is 1 cycle (single-sample frame) or 2 cycles (via ADD).
// Backpressure: in_ready drops during ADD and while a result waits in DONE for out_ready.
module fpadd_accumulator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ov,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_c,
    input  logic             add_ov
);

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        NEXT  = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        acc;
    logic [31:0]        b_reg;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_inc;
    logic               ov_sticky;
    logic               last_reg;

    // Count sticks at its maximum while accumulation keeps going.
    assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + 1'b1;

    // Adder operands come only from registers, so in_data never reaches the adder combinationally.
    assign add_a     = acc;
    assign add_b     = b_reg;
    assign out_sum   = acc;
    assign out_count = count;
    assign out_ov    = ov_sticky;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            FIRST: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = in_last ? DONE : NEXT;
            end
            NEXT: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ADD;
            end
            ADD: begin
                state_nxt = last_reg ? DONE : NEXT;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = FIRST;
            end
            default: state_nxt = FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FIRST;
            acc       <= 32'h0;
            b_reg     <= 32'h0;
            count     <= '0;
            ov_sticky <= 1'b0;
            last_reg  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                FIRST: begin
                    // Adder bypassed: a lone sample is reported bit-exact.
                    if (in_valid) begin
                        acc       <= in_data;
                        count     <= CNT_W'(1);
                        ov_sticky <= 1'b0;
                    end
                end
                NEXT: begin
                    if (in_valid) begin
                        b_reg    <= in_data;
                        last_reg <= in_last;
                        count    <= count_inc;
                    end
                end
                ADD: begin
                    acc       <= add_c;
                    ov_sticky <= ov_sticky | add_ov;
                end
                DONE: begin
                    if (out_ready) begin
                        acc       <= 32'h0;
                        count     <= '0;
                        ov_sticky <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpadd_accumulator.sv
// Directed bench for fpadd_accumulator; the FP adder is stood in for by a table of hand-computed sums.
module tb_fpadd_accumulator;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_sum;
    logic [CW-1:0] out_count;
    logic          out_ov;
    logic [31:0]   add_a;
    logic [31:0]   add_b;
    logic [31:0]   add_c;
    logic          add_ov;

    int passed = 0;
    int total  = 0;

    fpadd_accumulator #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ov    (out_ov),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c     (add_c),
        .add_ov    (add_ov)
    );

    always #5 clk = ~clk;

    // Known operand pairs only; anything else yields junk with ov set, which must never be sampled.
    function automatic logic [32:0] fake_add(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h42CDE666, 32'hC25909A8}: return {1'b0, 32'h4242C324};
            {32'h41700000, 32'hC1F00000}: return {1'b0, 32'hC1700000};
            {32'h41700000, 32'hC1700000}: return {1'b0, 32'h00000000};
            {32'h3F800000, 32'h41F00000}: return {1'b0, 32'h41F80000};
            {32'h41F80000, 32'hBF800000}: return {1'b0, 32'h41F00000};
            {32'h7F7FFFFF, 32'h7F7FFFFF}: return {1'b1, 32'h7F800000};
            {32'h7F800000, 32'h3F800000}: return {1'b0, 32'h7F800000};
            {32'h3F800000, 32'h3F800000}: return {1'b0, 32'h40000000};
            {32'h40000000, 32'h3F800000}: return {1'b0, 32'h40400000};
            {32'h40400000, 32'h3F800000}: return {1'b0, 32'h40800000};
            {32'h40800000, 32'h3F800000}: return {1'b0, 32'h40A00000};
            default:                      return {1'b1, 32'hDEADBEEF};
        endcase
    endfunction

    always_comb {add_ov, add_c} = fake_add(add_a, add_b);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = 32'h0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n + 1, exp_lat);
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("take_out_valid", {31'b0, out_valid}, 32'd0);
        chk("take_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_sum", out_sum, 32'h0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_ov", {31'b0, out_ov}, 32'd0);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_add_b", add_b, 32'h0);

        // 1: two-sample frame, operand presentation during ADD
        send(32'h42CDE666, 1'b0);
        send(32'hC25909A8, 1'b1);
        chk("t1_add_a", add_a, 32'h42CDE666);
        chk("t1_add_b", add_b, 32'hC25909A8);
        chk("t1_add_in_ready", {31'b0, in_ready}, 32'd0);
        wait_out("t1", 2);
        chk("t1_sum", out_sum, 32'h4242C324);
        chk("t1_count", 32'(out_count), 32'd2);
        chk("t1_ov", {31'b0, out_ov}, 32'd0);
        take_out();

        // 2: back-to-back frames, state cleared after transfer
        send(32'h41700000, 1'b0);
        send(32'hC1F00000, 1'b1);
        wait_out("t2a", 2);
        chk("t2a_sum", out_sum, 32'hC1700000);
        take_out();
        chk("t2_clr_sum", out_sum, 32'h0);
        chk("t2_clr_count", 32'(out_count), 32'd0);
        send(32'h41700000, 1'b0);
        send(32'hC1700000, 1'b1);
        wait_out("t2b", 2);
        chk("t2b_sum", out_sum, 32'h00000000);
        chk("t2b_count", 32'(out_count), 32'd2);
        take_out();

        // 3: three samples with idle gaps
        send(32'h3F800000, 1'b0);
        step(); step();
        send(32'h41F00000, 1'b0);
        chk("t3_add1_in_ready", {31'b0, in_ready}, 32'd0);
        step(); step(); step();
        send(32'hBF800000, 1'b1);
        chk("t3_add2_in_ready", {31'b0, in_ready}, 32'd0);
        wait_out("t3", 2);
        chk("t3_sum", out_sum, 32'h41F00000);
        chk("t3_count", 32'(out_count), 32'd3);
        take_out();

        // 4: single-sample frame held under backpressure
        send(32'hBF800000, 1'b1);
        wait_out("t4", 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 32'h12345678;
            in_last  = 1'b1;
            step();
            chk("t4_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("t4_hold_in_ready", {31'b0, in_ready}, 32'd0);
            chk("t4_hold_sum", out_sum, 32'hBF800000);
            chk("t4_hold_count", 32'(out_count), 32'd1);
        end
        in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
        take_out();

        // 5: overflow sticks for the frame, then clears
        send(32'h7F7FFFFF, 1'b0);
        send(32'h7F7FFFFF, 1'b0);
        step();
        send(32'h3F800000, 1'b1);
        wait_out("t5a", 2);
        chk("t5a_sum", out_sum, 32'h7F800000);
        chk("t5a_count", 32'(out_count), 32'd3);
        chk("t5a_ov", {31'b0, out_ov}, 32'd1);
        take_out();
        send(32'h3F800000, 1'b0);
        send(32'h41F00000, 1'b1);
        wait_out("t5b", 2);
        chk("t5b_sum", out_sum, 32'h41F80000);
        chk("t5b_ov", {31'b0, out_ov}, 32'd0);
        take_out();

        // count saturation: five samples, 2-bit counter stops at 3
        send(32'h3F800000, 1'b0);
        for (int i = 0; i < 3; i++) send(32'h3F800000, 1'b0);
        send(32'h3F800000, 1'b1);
        wait_out("sat", 2);
        chk("sat_sum", out_sum, 32'h40A00000);
        chk("sat_count", 32'(out_count), 32'd3);
        take_out();

        // 6: reset during ADD discards the partial frame
        send(32'h3F800000, 1'b0);
        send(32'h41F00000, 1'b0);
        chk("t6_in_add", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_in_ready", {31'b0, in_ready}, 32'd1);
        chk("t6_out_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_add_a", add_a, 32'h0);
        chk("t6_add_b", add_b, 32'h0);
        chk("t6_count", 32'(out_count), 32'd0);
        send(32'h3F800000, 1'b0);
        send(32'h41F00000, 1'b1);
        wait_out("t6", 2);
        chk("t6_sum", out_sum, 32'h41F80000);
        chk("t6_count2", 32'(out_count), 32'd2);
        chk("t6_ov", {31'b0, out_ov}, 32'd0);
        take_out();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fpadd_accumulator.md
Name: fpadd_accumulator

Overview:
- Sequencer and accumulator that sits directly upstream and downstream of the combinational 32-bit FP adder (fpadder_top).
- Accepts a stream of IEEE-754 single-precision samples on a valid/ready interface. It drives the adder operands from its running sum and the registered sample, then captures the adder result back into the running sum.
- On the frame's last sample it presents the frame sum, the sample count and a sticky overflow flag on a valid/ready output.
- The adder is instantiated beside this block at the next level up. Its a/b/c/ov connect to add_a/add_b/add_c/add_ov.

Parameters:
- CNT_W, 16, width of the per-frame sample counter; count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  sample available.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  32  FP32 sample.
- in_last  input  1  sample is the final one of its frame.
- out_valid  output  1  frame result held.
- out_ready  input  1  consumer takes the result.
- out_sum  output  32  FP32 frame sum.
- out_count  output  CNT_W  samples in the frame.
- out_ov  output  1  any adder overflow occurred during the frame.
- add_a  output  32  adder operand a (running sum).
- add_b  output  32  adder operand b (registered sample).
- add_c  input  32  adder result.
- add_ov  input  1  adder overflow flag.

Behaviour:
- Reset (rst=1 at a clk edge, from any state, including mid-frame or with out_valid high):
  - state=FIRST; acc, b_reg, count and ov_sticky cleared to 0; last_reg=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ov=0, add_a=0, add_b=0.
  - Any partial frame is discarded.
- A transfer occurs on an edge where valid and ready are both 1. in_ready is a pure function of state, with no combinational path from in_valid.
- States:
  - FIRST (in_ready=1):
    - On accept: acc<=in_data, count<=1, ov_sticky<=0. The adder is bypassed, so a lone sample's sum is bit-exact.
    - If in_last=1 go to DONE, else go to NEXT.
  - NEXT (in_ready=1):
    - On accept: b_reg<=in_data, last_reg<=in_last, count<=count+1 (saturating). Go to ADD.
    - With no accept, stay in NEXT.
  - ADD (in_ready=0), one cycle:
    - Outputs add_a=acc and add_b=b_reg.
    - At the edge: acc<=add_c, ov_sticky<=ov_sticky|add_ov.
    - Go to DONE if last_reg=1, else to NEXT.
  - DONE (in_ready=0):
    - out_valid=1; out_sum=acc, out_count=count, out_ov=ov_sticky, all held stable until the transfer.
    - On out_ready=1: clear acc, count and ov_sticky, then go to FIRST.
    - out_valid never drops without a transfer.
- add_a/add_b are registered values (acc, b_reg) in every state. They present no combinational path from in_data to the adder.
- The adder result is sampled only in ADD; add_c/add_ov are ignored in all other states.
- Throughput: first sample 1 cycle; each subsequent sample costs 2 cycles (accept + ADD).
- Latency from the last-sample accept to out_valid:
  - 1 cycle when the last sample is the first of its frame (FIRST→DONE).
  - 2 cycles otherwise (NEXT→ADD→DONE).
- out_ready is ignored while out_valid=0. in_valid is ignored while in_ready=0; the upstream source must hold in_data until accepted.
- Backpressure: while in DONE with out_ready=0, no new sample is accepted, and the next frame does not start until the result transfers.
- Count saturation: at 2^CNT_W-1 the count stays put while accumulation continues.
- ov_sticky is set by any ADD cycle with add_ov=1 and is cleared only by frame completion or reset.
- NaN, infinity and rounding behaviour are whatever the adder produces; this block never alters sum bits.

Test Plan:
1. Frame {0x42CDE666, 0xC25909A8(last)}, out_ready=1 → out_valid 2 cycles after the second accept; out_sum=0x4242C324, out_count=2, out_ov=0.
2. Frame {0x41700000, 0xC1F00000(last)} → out_sum=0xC1700000. Then frame {0x41700000, 0xC1700000(last)} → out_sum=0x00000000, count=2. Check that acc was cleared between frames.
3. Frame {0x3F800000, 0x41F00000, 0xBF800000(last)} with in_valid gaps → out_sum=0x41F00000, out_count=3; in_ready=0 in every ADD cycle.
4. Single-sample frame {0xBF800000(last)} → out_valid 1 cycle after accept, out_sum=0xBF800000, count=1. Hold out_ready=0 for 5 cycles: outputs are stable, in_ready=0, in_valid pulses are ignored. The result transfers when out_ready rises.
5. Frame {0x7F7FFFFF, 0x7F7FFFFF, 0x3F800000(last)} with the adder asserting ov on the first add → out_ov=1 at frame end; the next frame reports out_ov=0.
6. Assert rst during ADD of a 3-sample frame → the next cycle shows in_ready=1, out_valid=0, add_a=add_b=0. A following frame {0x3F800000, 0x41F00000(last)} gives 0x41F80000 with count=2.
